// File: rtl/fc_train_ctrl.sv
// Per-sample sequencer for the fc ternary-unit array: forward pass, optional
// backward pass driven by the error vector, result record and running stats.
module fc_train_ctrl #(
  parameter int N       = 27,
  parameter int CNT_W   = $clog2(N + 1),
  parameter int TIMEOUT = 1024,
  parameter int STAT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N-1:0]      s_fin,
  input  logic [N-1:0]      s_target,
  input  logic              s_train,
  output logic [N-1:0]      fin,
  output logic              fd_prop,
  input  logic [N-1:0]      fout,
  input  logic              fd_prop_done,
  output logic [N-1:0]      bin,
  output logic              bk_prop,
  input  logic              bk_prop_done,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [N-1:0]      r_fout,
  output logic [CNT_W-1:0]  r_errors,
  output logic              r_timeout,
  output logic              busy,
  output logic [STAT_W-1:0] stat_samples,
  output logic [STAT_W-1:0] stat_errors
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD_START = 3'd1,
    FWD_WAIT  = 3'd2,
    BWD_START = 3'd3,
    BWD_WAIT  = 3'd4,
    REPORT    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              s_ready_q, fd_prop_q, bk_prop_q, r_valid_q;
  logic              r_timeout_q, busy_q, train_q;
  logic [N-1:0]      fin_q, bin_q, r_fout_q, target_q;
  logic [CNT_W-1:0]  r_errors_q;
  logic [STAT_W-1:0] stat_samples_q, stat_errors_q;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic              accept, tmr_exp, r_hs;
  logic              fwd_done, fwd_to, bwd_done, bwd_to;
  logic [N-1:0]      err_vec;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

  always_comb begin
    accept   = (state_q == IDLE) && s_valid && s_ready_q;
    tmr_exp  = (timer_q == TMR_LAST);
    fwd_done = (state_q == FWD_WAIT) && fd_prop_done;
    fwd_to   = (state_q == FWD_WAIT) && !fd_prop_done && tmr_exp;
    bwd_done = (state_q == BWD_WAIT) && bk_prop_done;
    bwd_to   = (state_q == BWD_WAIT) && !bk_prop_done && tmr_exp;
    r_hs     = (state_q == REPORT) && r_ready;
    err_vec  = fout ^ target_q;

    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = FWD_START;
      FWD_START: state_d = FWD_WAIT;
      FWD_WAIT: begin
        if (fwd_done)    state_d = train_q ? BWD_START : REPORT;
        else if (fwd_to) state_d = REPORT;
      end
      BWD_START: state_d = BWD_WAIT;
      BWD_WAIT:  if (bwd_done || bwd_to) state_d = REPORT;
      REPORT:    if (r_hs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Timer reads 0 during the START cycle, so expiry at TIMEOUT-1 lands
    // exactly TIMEOUT cycles after the launch pulse.
    timer_d = '0;
    if (state_q inside {FWD_START, FWD_WAIT, BWD_START, BWD_WAIT}) begin
      timer_d = timer_q + 1'b1;
    end
    if (fwd_done && train_q) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      busy_q         <= 1'b0;
      s_ready_q      <= 1'b0;
      fd_prop_q      <= 1'b0;
      bk_prop_q      <= 1'b0;
      r_valid_q      <= 1'b0;
      r_timeout_q    <= 1'b0;
      train_q        <= 1'b0;
      fin_q          <= '0;
      bin_q          <= '0;
      r_fout_q       <= '0;
      r_errors_q     <= '0;
      stat_samples_q <= '0;
      stat_errors_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      busy_q    <= (state_d != IDLE);
      // Ready only after a full cycle in IDLE, giving the 4+k spacing.
      s_ready_q <= (state_q == IDLE) && !accept;
      fd_prop_q <= accept;
      bk_prop_q <= fwd_done && train_q;
      r_valid_q <= (state_d == REPORT);

      if (accept) begin
        fin_q       <= s_fin;
        train_q     <= s_train;
        r_timeout_q <= 1'b0;
      end

      if (fwd_done) begin
        r_fout_q   <= fout;
        bin_q      <= err_vec;
        r_errors_q <= popcount(err_vec);
      end

      if (fwd_to) begin
        r_timeout_q <= 1'b1;
        r_fout_q    <= '0;
        r_errors_q  <= '0;
      end

      if (bwd_to) begin
        r_timeout_q <= 1'b1;
      end

      if (r_hs) begin
        bin_q <= '0;
        if (!r_timeout_q) begin
          stat_samples_q <= sat_add(stat_samples_q, STAT_W'(1));
          stat_errors_q  <= sat_add(stat_errors_q, STAT_W'(r_errors_q));
        end
      end
    end
  end

  // Target only feeds the error vector, which is qualified by state.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      target_q <= s_target;
    end
  end

  assign s_ready      = s_ready_q;
  assign fin          = fin_q;
  assign fd_prop      = fd_prop_q;
  assign bin          = bin_q;
  assign bk_prop      = bk_prop_q;
  assign r_valid      = r_valid_q;
  assign r_fout       = r_fout_q;
  assign r_errors     = r_errors_q;
  assign r_timeout    = r_timeout_q;
  assign busy         = busy_q;
  assign stat_samples = stat_samples_q;
  assign stat_errors  = stat_errors_q;

endmodule

// File: tb/tb_fc_train_ctrl.sv
// Bench for fc_train_ctrl: directed and randomized samples against a
// transaction-level expectation of latency, results, error vector and stats.
module tb_fc_train_ctrl;
  localparam int N    = 27;
  localparam int TO   = 16;
  localparam int SW   = 6;
  localparam int CW   = $clog2(N + 1);
  localparam int SMAX = (1 << SW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          s_valid = 1'b0, s_train = 1'b0;
  logic          fd_prop_done = 1'b0, bk_prop_done = 1'b0, r_ready = 1'b0;
  logic [N-1:0]  s_fin = '0, s_target = '0, fout = '0;
  logic          s_ready, fd_prop, bk_prop, r_valid, r_timeout, busy;
  logic [N-1:0]  fin, bin, r_fout;
  logic [CW-1:0] r_errors;
  logic [SW-1:0] stat_samples, stat_errors;

  int errors = 0;
  int checks = 0;
  int exp_samples = 0;
  int exp_esum = 0;

  fc_train_ctrl #(.N(N), .TIMEOUT(TO), .STAT_W(SW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_fin(s_fin), .s_target(s_target), .s_train(s_train),
    .fin(fin), .fd_prop(fd_prop), .fout(fout), .fd_prop_done(fd_prop_done),
    .bin(bin), .bk_prop(bk_prop), .bk_prop_done(bk_prop_done),
    .r_valid(r_valid), .r_ready(r_ready), .r_fout(r_fout), .r_errors(r_errors),
    .r_timeout(r_timeout), .busy(busy), .stat_samples(stat_samples), .stat_errors(stat_errors)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " s_ready"}, s_ready, 0);
    chk({tag, " fin"}, fin, 0);
    chk({tag, " fd_prop"}, fd_prop, 0);
    chk({tag, " bin"}, bin, 0);
    chk({tag, " bk_prop"}, bk_prop, 0);
    chk({tag, " r_valid"}, r_valid, 0);
    chk({tag, " r_fout"}, r_fout, 0);
    chk({tag, " r_errors"}, r_errors, 0);
    chk({tag, " r_timeout"}, r_timeout, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " stat_samples"}, stat_samples, 0);
    chk({tag, " stat_errors"}, stat_errors, 0);
  endtask

  // Entered at the falling edge of an idle cycle where s_ready should be 1;
  // returns at the falling edge of the next such cycle.
  task automatic run_sample(input logic [N-1:0] fi, input logic [N-1:0] tg, input logic tr,
                            input logic [N-1:0] fo, input int kf, input int kb, input int rwait,
                            input bit hold, input bit spur, input int abort_c);
    bit           fwd_ok, bwd_ok, exp_to;
    int           bkc, rc, hc, exp_err;
    logic [N-1:0] exp_bin, exp_rfout;
    fwd_ok    = (kf >= 1) && (kf <= TO - 1);
    bwd_ok    = (kb >= 1) && (kb <= TO - 1);
    bkc       = (tr && fwd_ok) ? kf + 2 : -1;
    if (!fwd_ok)  rc = TO + 1;
    else if (!tr) rc = kf + 2;
    else          rc = bwd_ok ? bkc + kb + 1 : bkc + TO;
    hc        = rc + rwait;
    exp_to    = !fwd_ok || (tr && !bwd_ok);
    exp_bin   = fwd_ok ? (fo ^ tg) : '0;
    exp_rfout = fwd_ok ? fo : '0;
    exp_err   = fwd_ok ? $countones(fo ^ tg) : 0;

    chk("idle s_ready", s_ready, 1);
    chk("idle busy", busy, 0);
    chk("idle r_valid", r_valid, 0);
    chk("idle bin", bin, 0);
    s_valid = 1'b1; s_fin = fi; s_target = tg; s_train = tr; r_ready = 1'b0;
    fd_prop_done = spur; bk_prop_done = 1'b0; fout = N'($urandom);

    for (int c = 1; c <= hc + 1; c++) begin
      @(negedge clk_in);
      if (c <= hc) begin
        chk($sformatf("fd_prop c%0d", c), fd_prop, (c == 1));
        chk($sformatf("bk_prop c%0d", c), bk_prop, (c == bkc));
        chk($sformatf("r_valid c%0d", c), r_valid, (c >= rc));
        chk($sformatf("busy c%0d", c), busy, 1);
        chk($sformatf("s_ready c%0d", c), s_ready, 0);
        chk($sformatf("fin c%0d", c), fin, fi);
        chk($sformatf("bin c%0d", c), bin, (fwd_ok && c >= kf + 2) ? exp_bin : '0);
        chk($sformatf("r_timeout c%0d", c), r_timeout, (c >= rc) ? exp_to : 1'b0);
        if (c >= rc) begin
          chk($sformatf("r_fout c%0d", c), r_fout, exp_rfout);
          chk($sformatf("r_errors c%0d", c), r_errors, exp_err);
        end
        chk($sformatf("stat_samples c%0d", c), stat_samples, exp_samples);
        chk($sformatf("stat_errors c%0d", c), stat_errors, exp_esum);
      end else begin
        if (!exp_to) begin
          exp_samples = (exp_samples + 1 > SMAX) ? SMAX : exp_samples + 1;
          exp_esum    = (exp_esum + exp_err > SMAX) ? SMAX : exp_esum + exp_err;
        end
        chk("post r_valid", r_valid, 0);
        chk("post busy", busy, 0);
        chk("post s_ready", s_ready, 0);
        chk("post bin", bin, 0);
        chk("post r_fout", r_fout, exp_rfout);
        chk("post r_timeout", r_timeout, exp_to);
        chk("post stat_samples", stat_samples, exp_samples);
        chk("post stat_errors", stat_errors, exp_esum);
      end

      if (c == abort_c) begin
        rst_in = 1'b0;
        #1;
        chk_all_zero("abort");
        s_valid = 1'b0; fd_prop_done = 1'b0; bk_prop_done = 1'b0; r_ready = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("abort release s_ready", s_ready, 0);
        @(negedge clk_in);
        chk("abort s_ready after edge", s_ready, 1);
        chk("abort busy", busy, 0);
        chk("abort stat_samples", stat_samples, 0);
        exp_samples = 0;
        exp_esum    = 0;
        return;
      end

      fd_prop_done = ((kf >= 1) && (c == 1 + kf)) || (spur && (c == 1 || c == hc + 1));
      bk_prop_done = ((bkc > 0) && (kb >= 1) && (c == bkc + kb)) || (spur && (c == 2));
      fout         = (c == 1 + kf) ? fo : N'($urandom);
      r_ready      = (c < rc) ? 1'($urandom_range(0, 1)) : (c == hc);
      s_valid      = hold;
      s_fin        = ~fi;
    end
    @(negedge clk_in);
  endtask

  initial begin
    logic [N-1:0] a, b, d;
    int kf, kb;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk_all_zero("reset");
    rst_in = 1'b1;
    #1;
    chk("reset release s_ready", s_ready, 0);
    @(negedge clk_in);

    // Inference: fout=7 against target 0, done 3 cycles after fd_prop.
    run_sample(27'h1, 27'h0, 1'b0, 27'h7, 3, 0, 0, 1'b0, 1'b0, 0);
    chk("tp1 r_fout", r_fout, 27'h7);
    chk("tp1 r_errors", r_errors, 3);
    chk("tp1 stat_samples", stat_samples, 1);
    chk("tp1 stat_errors", stat_errors, 3);

    // Training: error vector 5^4 = 1, backward done 2 cycles after bk_prop.
    run_sample(27'h2A, 27'h4, 1'b1, 27'h5, 2, 2, 0, 1'b0, 1'b0, 0);
    chk("tp2 r_errors", r_errors, 1);
    chk("tp2 stat_errors", stat_errors, 4);

    // Forward timeout: no done at all.
    run_sample(27'h123, 27'h456, 1'b0, 27'h789, 0, 0, 1, 1'b0, 1'b0, 0);
    chk("tp3 stat_samples", stat_samples, 2);
    chk("tp3 r_fout", r_fout, 0);

    // Result back-pressure with s_valid held high, then spurious done pulses.
    run_sample(27'h7FFFFFF, 27'h0, 1'b0, 27'h3, 5, 0, 5, 1'b1, 1'b0, 0);
    run_sample(27'h55, 27'hF0, 1'b1, 27'h0F, 4, 3, 2, 1'b0, 1'b1, 0);

    // Done coinciding with the timeout cycle, then a backward timeout.
    run_sample(27'h11, 27'h22, 1'b1, 27'h33, TO - 1, TO - 1, 0, 1'b0, 1'b0, 0);
    run_sample(27'h44, 27'h7FFFFFF, 1'b1, 27'h1, 2, 0, 0, 1'b0, 1'b0, 0);

    // Reset while waiting for bk_prop_done.
    run_sample(27'h99, 27'h66, 1'b1, 27'h77, 2, 10, 0, 1'b0, 1'b0, 7);

    for (int i = 0; i < 80; i++) begin
      a  = N'($urandom);
      b  = N'($urandom);
      d  = N'($urandom);
      kf = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO - 1);
      kb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO - 1);
      run_sample(a, b, 1'($urandom_range(0, 1)), d, kf, kb, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    s_valid = 1'b0;
    chk("final stat_samples", stat_samples, exp_samples);
    chk("final stat_errors", stat_errors, exp_esum);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
